// File: rtl/leaf_out_arbiter_pkg.sv
// Shared definitions for the leaf output arbiter: FSM state encoding and a
// constant-evaluable ceil(log2) helper used to size index and counter fields.
package leaf_out_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector.
// Ports: mask/request - per-requester enable and request vectors
//        last_idx     - most recently granted index; search starts at last_idx+1
//        vld          - some requester is both enabled and requesting
//        idx          - first eligible requester in round-robin order
module rr_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] last_idx,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] eligible;

    assign eligible = mask & request;

    // Walk offsets from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        int unsigned pos;
        logic [IDX_W-1:0] cand;
        vld  = 1'b0;
        idx  = '0;
        pos  = 0;
        cand = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            pos  = (32'(last_idx) + k) % N;
            cand = IDX_W'(pos);
            if (eligible[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: shares one registered output port among NUM_REQ
// requesters with round-robin grants of up to BURST_MAX words each.
// Ports: clk, reset_n (async, active low)
//        din_req/vld_req/ack_req - per-requester stream inputs and accepts
//        req_mask                - per-requester arbitration enable
//        dout/vld_out/ack_in     - registered output stream toward the leaf
//        grant_idx               - current/last granted requester
//        busy                    - high while a grant is active
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned BURST_MAX    = 16,
    localparam int unsigned IDX_W       = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    input  logic [NUM_REQ-1:0]              req_mask,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            vld_out,
    input  logic                            ack_in,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            busy
);

    localparam int unsigned CNT_W = clog2(BURST_MAX) + 1;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0]  dout_q, dout_d;
    logic                     vld_q, vld_d;

    logic [PAYLOAD_BITS-1:0]  req_word [NUM_REQ];
    logic [PAYLOAD_BITS-1:0]  cur_word;
    logic                     grant_vld;
    logic                     can_accept;
    logic                     xfer;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     sel_vld;
    logic [IDX_W-1:0]         sel_idx;

    // Unpack the flat requester bus into one word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign req_word[g] = din_req[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    rr_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .mask     (req_mask),
        .request  (vld_req),
        .last_idx (grant_q),
        .vld      (sel_vld),
        .idx      (sel_idx)
    );

    assign cur_word   = req_word[grant_q];
    assign grant_vld  = vld_req[grant_q] & req_mask[grant_q];
    assign can_accept = !vld_q || ack_in;
    assign xfer       = (state_q == ST_GRANT) && grant_vld && can_accept;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // Accept only for the granted requester; a masked-off grant never
    // acknowledges, so a requester cannot believe a dropped word was taken.
    always_comb begin
        ack_req = '0;
        if ((state_q == ST_GRANT) && req_mask[grant_q] && can_accept) begin
            ack_req[grant_q] = 1'b1;
        end
    end

    // Next-state: output register and arbitration FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vld_d   = vld_q;

        if (xfer) begin
            dout_d = cur_word;
            vld_d  = 1'b1;
        end else if (ack_in) begin
            vld_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    grant_d = sel_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!grant_vld) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BURST_MAX)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; grant resets to the last index so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    assign dout      = dout_q;
    assign vld_out   = vld_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed testbench for leaf_out_arbiter. Each requester streams words
// tagged {requester[7:0], sequence[23:0]}; the output stream is logged.
module tb_leaf_out_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned PB = 32;
    localparam int unsigned BM = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NR*PB-1:0]   din_req;
    logic [NR-1:0]      vld_req;
    logic [NR-1:0]      ack_req;
    logic [NR-1:0]      req_mask;
    logic [PB-1:0]      dout;
    logic               vld_out;
    logic               ack_in;
    logic [1:0]         grant_idx;
    logic               busy;

    int                 sent  [NR];
    int                 limit [NR];
    logic [PB-1:0]      out_q [$];
    logic               vlog  [$];
    logic               blog  [$];
    logic [1:0]         glog  [$];
    int                 errors = 0;
    int                 checks = 0;

    always #5 clk = ~clk;

    leaf_out_arbiter #(
        .NUM_REQ      (NR),
        .PAYLOAD_BITS (PB),
        .BURST_MAX    (BM)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din_req   (din_req),
        .vld_req   (vld_req),
        .ack_req   (ack_req),
        .req_mask  (req_mask),
        .dout      (dout),
        .vld_out   (vld_out),
        .ack_in    (ack_in),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    function automatic logic [PB-1:0] tag(input int r, input int s);
        return {8'(r), 24'(s)};
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            vld_req[i]          = (sent[i] < limit[i]);
            din_req[i*PB +: PB] = tag(i, sent[i]);
        end
    endtask

    // One clock: present inputs, log outputs, account transfers, advance to next negedge.
    task automatic step();
        logic [NR-1:0] fire;
        drive();
        #1;
        vlog.push_back(vld_out);
        blog.push_back(busy);
        glog.push_back(grant_idx);
        if (vld_out && ack_in) out_q.push_back(dout);
        fire = vld_req & ack_req;
        for (int i = 0; i < NR; i++) if (fire[i]) sent[i]++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NR; i++) begin
            sent[i]  = 0;
            limit[i] = 0;
        end
        out_q.delete();
        vlog.delete();
        blog.delete();
        glog.delete();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        ack_in   = 1'b1;
        req_mask = '1;
        clear_logs();
        drive();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", vld_out); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %0h want 0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (ack_req !== '0) begin errors++; $display("FAIL reset_ack: got %0b want 0", ack_req); end
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d want 3", grant_idx); end
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        logic ok;
        do_reset();
        limit[0] = 20;
        repeat (26) step();
        ok = (out_q.size() == 20);
        for (int k = 0; k < out_q.size() && ok; k++) if (out_q[k] !== tag(0, k)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_seq: got %0d words want 20 in order", out_q.size()); end
        // 16 back-to-back, one bubble, 4 more.
        ok = (vlog[0] === 1'b0) && (vlog[1] === 1'b0) && (vlog[18] === 1'b0) && (vlog[23] === 1'b0);
        for (int k = 2; k <= 17; k++) if (vlog[k] !== 1'b1) ok = 1'b0;
        for (int k = 19; k <= 22; k++) if (vlog[k] !== 1'b1) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_bubble: got vld_out pattern wrong want 16 on, 1 off, 4 on"); end
        checks++; if (blog[17] !== 1'b0 || blog[16] !== 1'b1) begin errors++; $display("FAIL single_idle: got busy %0b/%0b want 1/0", blog[16], blog[17]); end
        ok = 1'b1;
        for (int k = 1; k < glog.size(); k++) if (glog[k] !== 2'd0) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_grant: got grant_idx not 0 want 0 throughout"); end
    endtask

    task automatic test_alternate();
        logic ok;
        int   r, base;
        do_reset();
        limit[1] = 32;
        limit[3] = 32;
        repeat (75) step();
        ok = (out_q.size() == 64);
        for (int b = 0; b < 4 && ok; b++) begin
            r    = (b % 2 == 0) ? 1 : 3;
            base = (b / 2) * 16;
            for (int k = 0; k < 16; k++) if (out_q[b*16 + k] !== tag(r, base + k)) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL alt_seq: got %0d words want 64 as bursts 1,3,1,3 of 16", out_q.size()); end
    endtask

    task automatic test_backpressure();
        logic ok;
        int   n;
        do_reset();
        limit[2] = 4;
        n = 0;
        while (!vld_out && n < 10) begin step(); n++; end
        checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL bp_first: got vld_out %0b want 1 within 10 cycles", vld_out); end
        checks++; if (dout !== tag(2, 0)) begin errors++; $display("FAIL bp_word0: got %0h want %0h", dout, tag(2, 0)); end
        ack_in = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (dout !== tag(2, 0) || vld_out !== 1'b1 || ack_req[2] !== 1'b0) ok = 1'b0;
            step();
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_freeze: got dout %0h ack %0b want frozen %0h ack 0", dout, ack_req, tag(2, 0)); end
        ack_in = 1'b1;
        repeat (10) step();
        ok = (out_q.size() == 4);
        for (int k = 0; k < out_q.size() && ok; k++) if (out_q[k] !== tag(2, k)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL bp_seq: got %0d words want 4 unique in order", out_q.size()); end
    endtask

    task automatic test_mask();
        logic ok;
        int   r, base;
        do_reset();
        req_mask = 4'b1011;
        for (int i = 0; i < NR; i++) limit[i] = 20;
        repeat (70) step();
        ok = (out_q.size() >= 52);
        for (int b = 0; b < 3 && ok; b++) begin
            r = (b == 0) ? 0 : ((b == 1) ? 1 : 3);
            for (int k = 0; k < 16; k++) if (out_q[b*16 + k] !== tag(r, k)) ok = 1'b0;
        end
        for (int k = 0; k < 4 && ok; k++) if (out_q[48 + k] !== tag(0, 16 + k)) ok = 1'b0;
        base = 0;
        for (int k = 0; k < out_q.size(); k++) if (out_q[k][31:24] === 8'd2) base++;
        checks++; if (!ok) begin errors++; $display("FAIL mask_order: got %0d words want order 0,1,3,0", out_q.size()); end
        checks++; if (base != 0 || sent[2] != 0) begin errors++; $display("FAIL mask_excl: got %0d words from req2 want 0", base + sent[2]); end
    endtask

    task automatic test_drop();
        logic ok;
        do_reset();
        limit[0] = 3;
        limit[1] = 5;
        repeat (14) step();
        checks++; if (blog[4] !== 1'b1 || blog[5] !== 1'b0 || blog[6] !== 1'b1) begin errors++; $display("FAIL drop_fsm: got busy %0b%0b%0b want 101", blog[4], blog[5], blog[6]); end
        checks++; if (glog[6] !== 2'd1) begin errors++; $display("FAIL drop_grant: got %0d want 1", glog[6]); end
        ok = (out_q.size() == 8);
        for (int k = 0; k < 3 && ok; k++) if (out_q[k] !== tag(0, k)) ok = 1'b0;
        for (int k = 0; k < 5 && ok; k++) if (out_q[3 + k] !== tag(1, k)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL drop_seq: got %0d words want 3 from req0 then 5 from req1", out_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        do_reset();
        limit[0] = 20;
        n = 0;
        while (sent[0] < 8 && n < 20) begin step(); n++; end
        checks++; if (vld_out !== 1'b1 || dout !== tag(0, 7)) begin errors++; $display("FAIL rst_pending: got %0b/%0h want 1/%0h", vld_out, dout, tag(0, 7)); end
        ack_in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (vld_out !== 1'b0 || dout !== '0) begin errors++; $display("FAIL rst_async: got %0b/%0h want 0/0", vld_out, dout); end
        checks++; if (busy !== 1'b0 || ack_req !== '0 || grant_idx !== 2'd3) begin errors++; $display("FAIL rst_state: got busy %0b ack %0b grant %0d want 0 0 3", busy, ack_req, grant_idx); end
        @(negedge clk);
        clear_logs();
        ack_in   = 1'b1;
        limit[0] = 2;
        limit[1] = 2;
        drive();
        reset_n = 1'b1;
        repeat (6) step();
        checks++; if (glog[1] !== 2'd0) begin errors++; $display("FAIL rst_regrant: got %0d want 0", glog[1]); end
        checks++; if (out_q.size() < 1 || out_q[0] !== tag(0, 0)) begin errors++; $display("FAIL rst_first: got %0d words want first %0h", out_q.size(), tag(0, 0)); end
    endtask

    initial begin
        reset_n  = 1'b0;
        ack_in   = 1'b1;
        req_mask = '1;
        vld_req  = '0;
        din_req  = '0;
        clear_logs();
        test_reset();
        test_single_burst();
        test_alternate();
        test_backpressure();
        test_mask();
        test_drop();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
